// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with main decode, bubble/hold control and counters
module id_ex_stage #(
  parameter int unsigned CNT_W    = 16,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      ifid_o,
  input  logic [31:0]      qa,
  input  logic [31:0]      qb,
  input  logic             stall,
  input  logic             flush,
  input  logic             hold,
  output logic             ex_valid,
  output logic             ex_wreg,
  output logic             ex_m2reg,
  output logic             ex_wmem,
  output logic             ex_aluimm,
  output logic             ex_branch,
  output logic [3:0]       ex_aluc,
  output logic [4:0]       ex_dest,
  output logic [31:0]      ex_qa,
  output logic [31:0]      ex_qb,
  output logic [31:0]      ex_imm32,
  output logic             ex_illegal,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef struct packed {
    logic        valid;
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    logic        aluimm;
    logic        branch;
    logic [3:0]  aluc;
    logic [4:0]  dest;
    logic [31:0] qa;
    logic [31:0] qb;
    logic [31:0] imm32;
    logic        illegal;
  } ex_t;

  ex_t              dec, ex_d, ex_q;
  logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
  logic [CNT_W-1:0] illegal_cnt_d, illegal_cnt_q;
  logic [5:0]       op, funct;
  logic [4:0]       rt, rd;

  assign op    = ifid_o[31:26];
  assign rt    = ifid_o[20:16];
  assign rd    = ifid_o[15:11];
  assign funct = ifid_o[5:0];

  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    dec.qa    = qa;
    dec.qb    = qb;
    dec.imm32 = {{16{ifid_o[15]}}, ifid_o[15:0]};
    if (ifid_o != NOP_WORD) begin
      case (op)
        6'h00: begin
          dec.wreg = 1'b1;
          dec.dest = rd;
          case (funct)
            6'h20:   dec.aluc = 4'b0010;
            6'h22:   dec.aluc = 4'b0110;
            6'h24:   dec.aluc = 4'b0000;
            6'h25:   dec.aluc = 4'b0001;
            6'h2A:   dec.aluc = 4'b0111;
            default: begin
              dec.wreg    = 1'b0;
              dec.dest    = 5'd0;
              dec.illegal = 1'b1;
            end
          endcase
        end
        6'h23: begin
          dec.wreg   = 1'b1;
          dec.m2reg  = 1'b1;
          dec.aluimm = 1'b1;
          dec.aluc   = 4'b0010;
          dec.dest   = rt;
        end
        6'h2B: begin
          dec.wmem   = 1'b1;
          dec.aluimm = 1'b1;
          dec.aluc   = 4'b0010;
        end
        6'h08: begin
          dec.wreg   = 1'b1;
          dec.aluimm = 1'b1;
          dec.aluc   = 4'b0010;
          dec.dest   = rt;
        end
        6'h04: begin
          dec.branch = 1'b1;
          dec.aluc   = 4'b0110;
        end
        default: dec.illegal = 1'b1;
      endcase
    end
    // $0 is hardwired; never let a write to it reach writeback
    if (dec.dest == 5'd0) dec.wreg = 1'b0;
  end

  always_comb begin
    ex_d          = ex_q;
    bubble_cnt_d  = bubble_cnt_q;
    illegal_cnt_d = illegal_cnt_q;
    if (flush || (stall && !hold)) begin
      ex_d = '0;
      if (bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end else if (hold) begin
      ex_d.illegal = 1'b0;
    end else begin
      ex_d = dec;
      if (dec.illegal && (illegal_cnt_q != '1)) illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q          <= '0;
      bubble_cnt_q  <= '0;
      illegal_cnt_q <= '0;
    end else begin
      ex_q          <= ex_d;
      bubble_cnt_q  <= bubble_cnt_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_wreg     = ex_q.wreg;
  assign ex_m2reg    = ex_q.m2reg;
  assign ex_wmem     = ex_q.wmem;
  assign ex_aluimm   = ex_q.aluimm;
  assign ex_branch   = ex_q.branch;
  assign ex_aluc     = ex_q.aluc;
  assign ex_dest     = ex_q.dest;
  assign ex_qa       = ex_q.qa;
  assign ex_qb       = ex_q.qb;
  assign ex_imm32    = ex_q.imm32;
  assign ex_illegal  = ex_q.illegal;
  assign bubble_cnt  = bubble_cnt_q;
  assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - randomized and directed checks of id_ex_stage against a behavioural model
module tb_id_ex_stage;

  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   ifid_o = '0, qa = '0, qb = '0;
  logic          stall = 1'b0, flush = 1'b0, hold = 1'b0;
  logic          ex_valid, ex_wreg, ex_m2reg, ex_wmem, ex_aluimm, ex_branch, ex_illegal;
  logic [3:0]    ex_aluc;
  logic [4:0]    ex_dest;
  logic [31:0]   ex_qa, ex_qb, ex_imm32;
  logic [CW-1:0] bubble_cnt, illegal_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  id_ex_stage #(.CNT_W(CW), .NOP_WORD(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .ifid_o(ifid_o), .qa(qa), .qb(qb),
    .stall(stall), .flush(flush), .hold(hold),
    .ex_valid(ex_valid), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_wmem(ex_wmem),
    .ex_aluimm(ex_aluimm), .ex_branch(ex_branch), .ex_aluc(ex_aluc), .ex_dest(ex_dest),
    .ex_qa(ex_qa), .ex_qb(ex_qb), .ex_imm32(ex_imm32), .ex_illegal(ex_illegal),
    .bubble_cnt(bubble_cnt), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit valid, wreg, m2reg, wmem, aluimm, branch, illegal;
    bit [3:0]  aluc;
    bit [4:0]  dest;
    bit [31:0] qa, qb, imm;
  } exp_t;

  exp_t m;
  int   m_bcnt = 0;
  int   m_icnt = 0;

  function automatic int funct_aluc(bit [5:0] f);
    case (f)
      6'h20: return 2;
      6'h22: return 6;
      6'h24: return 0;
      6'h25: return 1;
      6'h2A: return 7;
      default: return -1;
    endcase
  endfunction

  // Expected EX slot for a normally-advancing instruction word
  function automatic exp_t ref_decode(bit [31:0] w, bit [31:0] a, bit [31:0] b);
    exp_t e = '{default: 0};
    bit   writes = 0;
    int   ac;
    e.valid = 1;
    e.qa    = a;
    e.qb    = b;
    e.imm   = w[15] ? (32'hFFFF0000 | {16'h0, w[15:0]}) : {16'h0, w[15:0]};
    if (w == 32'h0) return e;
    ac = funct_aluc(w[5:0]);
    if (w[31:26] == 6'h00 && ac >= 0) begin
      e.aluc = 4'(ac); e.dest = w[15:11]; writes = 1;
    end else if (w[31:26] == 6'h23) begin
      e.m2reg = 1; e.aluimm = 1; e.aluc = 4'd2; e.dest = w[20:16]; writes = 1;
    end else if (w[31:26] == 6'h2B) begin
      e.wmem = 1; e.aluimm = 1; e.aluc = 4'd2;
    end else if (w[31:26] == 6'h08) begin
      e.aluimm = 1; e.aluc = 4'd2; e.dest = w[20:16]; writes = 1;
    end else if (w[31:26] == 6'h04) begin
      e.branch = 1; e.aluc = 4'd6;
    end else begin
      e.illegal = 1;
    end
    e.wreg = writes && (e.dest != 0);
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m = '{default: 0}; m_bcnt = 0; m_icnt = 0;
    end else if (flush || (stall && !hold)) begin
      m = '{default: 0};
      m_bcnt = (m_bcnt < CMAX) ? m_bcnt + 1 : CMAX;
    end else if (hold) begin
      m.illegal = 0;
    end else begin
      m = ref_decode(ifid_o, qa, qb);
      if (m.illegal) m_icnt = (m_icnt < CMAX) ? m_icnt + 1 : CMAX;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("valid",   32'(ex_valid),   32'(m.valid));
      chk("wreg",    32'(ex_wreg),    32'(m.wreg));
      chk("m2reg",   32'(ex_m2reg),   32'(m.m2reg));
      chk("wmem",    32'(ex_wmem),    32'(m.wmem));
      chk("aluimm",  32'(ex_aluimm),  32'(m.aluimm));
      chk("branch",  32'(ex_branch),  32'(m.branch));
      chk("illegal", 32'(ex_illegal), 32'(m.illegal));
      chk("aluc",    32'(ex_aluc),    32'(m.aluc));
      chk("dest",    32'(ex_dest),    32'(m.dest));
      chk("qa",      ex_qa,           m.qa);
      chk("qb",      ex_qb,           m.qb);
      chk("imm32",   ex_imm32,        m.imm);
      chk("bubble_cnt",  32'(bubble_cnt),  32'(m_bcnt));
      chk("illegal_cnt", 32'(illegal_cnt), 32'(m_icnt));
    end
  end

  // Drive one cycle of inputs at a falling edge, return at the next falling edge
  task automatic cyc(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b,
                     input logic st, input logic fl, input logic ho);
    ifid_o = w; qa = a; qb = b; stall = st; flush = fl; hold = ho;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w = $urandom;
    case ($urandom_range(0, 7))
      0: begin
        w[31:26] = 6'h00;
        case ($urandom_range(0, 5))
          0: w[5:0] = 6'h20; 1: w[5:0] = 6'h22; 2: w[5:0] = 6'h24;
          3: w[5:0] = 6'h25; 4: w[5:0] = 6'h2A; default: ;
        endcase
      end
      1: w[31:26] = 6'h23;
      2: w[31:26] = 6'h2B;
      3: w[31:26] = 6'h08;
      4: w[31:26] = 6'h04;
      5: w = 32'h0;
      default: ;
    endcase
    if ($urandom_range(0, 7) == 0) w[20:11] = '0;
    return w;
  endfunction

  localparam logic [31:0] ADD  = 32'h014B4820;
  localparam logic [31:0] LW   = 32'h8C22FFFC;
  localparam logic [31:0] SW   = 32'hAC220008;
  localparam logic [31:0] BAD  = 32'hFC000000;
  localparam logic [31:0] ADDI = 32'h20200005;

  initial begin
    @(negedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst valid", 32'(ex_valid), 0);
    chk("rst bubble_cnt", 32'(bubble_cnt), 0);
    rst_n = 1'b1;

    cyc(ADD, 32'd5, 32'd7, 0, 0, 0);
    chk("add valid", 32'(ex_valid), 1);
    chk("add wreg", 32'(ex_wreg), 1);
    chk("add aluc", 32'(ex_aluc), 32'h2);
    chk("add dest", 32'(ex_dest), 9);
    chk("add qa", ex_qa, 5);
    chk("add qb", ex_qb, 7);

    cyc(LW, 32'd1, 32'd2, 0, 0, 0);
    chk("lw m2reg", 32'(ex_m2reg), 1);
    chk("lw aluimm", 32'(ex_aluimm), 1);
    chk("lw dest", 32'(ex_dest), 2);
    chk("lw imm32", ex_imm32, 32'hFFFFFFFC);
    cyc(SW, 32'd1, 32'd2, 0, 0, 0);
    chk("sw wmem", 32'(ex_wmem), 1);
    chk("sw wreg", 32'(ex_wreg), 0);
    chk("sw imm32", ex_imm32, 32'h8);

    cyc(LW, 32'd3, 32'd4, 1, 0, 0);
    chk("stall valid", 32'(ex_valid), 0);
    chk("stall m2reg", 32'(ex_m2reg), 0);
    chk("stall bubble_cnt", 32'(bubble_cnt), 1);
    cyc(LW, 32'd3, 32'd4, 1, 1, 0);
    chk("stall+flush bubble_cnt", 32'(bubble_cnt), 2);
    for (int i = 0; i < 4; i++) cyc(ADD, 32'd0, 32'd0, 0, 1, 0);
    chk("bubble saturate", 32'(bubble_cnt), 3);

    cyc(ADD, 32'd11, 32'd22, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(LW, $urandom, $urandom, 0, 0, 1);
    chk("hold dest", 32'(ex_dest), 9);
    chk("hold qa", ex_qa, 11);
    chk("hold m2reg", 32'(ex_m2reg), 0);
    cyc(LW, 32'd0, 32'd0, 0, 1, 1);
    chk("hold+flush valid", 32'(ex_valid), 0);
    cyc(ADD, 32'd11, 32'd22, 0, 0, 0);
    cyc(LW, 32'd0, 32'd0, 1, 0, 1);
    chk("hold+stall valid", 32'(ex_valid), 1);
    chk("hold+stall dest", 32'(ex_dest), 9);
    chk("hold+stall bubble_cnt", 32'(bubble_cnt), 3);

    cyc(BAD, 32'd0, 32'd0, 0, 0, 0);
    chk("bad illegal", 32'(ex_illegal), 1);
    chk("bad illegal_cnt", 32'(illegal_cnt), 1);
    chk("bad dest", 32'(ex_dest), 0);
    cyc(BAD, 32'd0, 32'd0, 0, 0, 1);
    chk("bad held illegal", 32'(ex_illegal), 0);
    chk("bad held illegal_cnt", 32'(illegal_cnt), 1);
    cyc(32'h0, 32'd0, 32'd0, 0, 0, 0);
    chk("nop illegal", 32'(ex_illegal), 0);
    chk("nop valid", 32'(ex_valid), 1);
    cyc(ADDI, 32'd0, 32'd0, 0, 0, 0);
    chk("addi $0 wreg", 32'(ex_wreg), 0);
    chk("addi $0 aluimm", 32'(ex_aluimm), 1);

    cyc(ADD, 32'd5, 32'd7, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst valid", 32'(ex_valid), 0);
    chk("async rst qa", ex_qa, 0);
    chk("async rst aluc", 32'(ex_aluc), 0);
    chk("async rst bubble_cnt", 32'(bubble_cnt), 0);
    chk("async rst illegal_cnt", 32'(illegal_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      cyc(rand_word(), $urandom, $urandom,
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 14) == 0), ($urandom_range(0, 7) == 0));
    end

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
